// File: rtl/valid_ready_multichannel_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : valid_ready_multichannel_fifo_if
// Description : Handshake bundle for the multi-channel FIFO. The write side
//               and the arbitrated read side share one bundle. The optional
//               almost-full flags exist only when
//               VALID_READY_MULTICHANNEL_FIFO_ALMOST_FULL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface valid_ready_multichannel_fifo_if #(
    parameter int WIDTH         = 8,
    parameter int CHANNELS      = 4,
    parameter int CHANNEL_WIDTH = $clog2(CHANNELS)
);
    logic [WIDTH-1:0]         write_data;
    logic [CHANNEL_WIDTH-1:0] write_channel;
    logic                     write_valid;
    logic                     write_ready;
    logic [CHANNELS-1:0]      write_full;
`ifdef VALID_READY_MULTICHANNEL_FIFO_ALMOST_FULL_EN
    logic [CHANNELS-1:0]      write_almost_full;
`endif
    logic [WIDTH-1:0]         read_data;
    logic [CHANNEL_WIDTH-1:0] read_channel;
    logic                     read_valid;
    logic                     read_ready;
    logic [CHANNELS-1:0]      read_empty;

    // Producer/consumer side: drives requests, observes flags and read port
    modport master (
        output write_data, write_channel, write_valid, read_ready,
        input  write_ready, write_full, read_data, read_channel, read_valid,
`ifdef VALID_READY_MULTICHANNEL_FIFO_ALMOST_FULL_EN
        input  write_almost_full,
`endif
        input  read_empty
    );

    // FIFO side
    modport slave (
        input  write_data, write_channel, write_valid, read_ready,
        output write_ready, write_full, read_data, read_channel, read_valid,
`ifdef VALID_READY_MULTICHANNEL_FIFO_ALMOST_FULL_EN
        output write_almost_full,
`endif
        output read_empty
    );
endinterface
`default_nettype wire

// File: rtl/valid_ready_multichannel_fifo.sv
`default_nettype none
// ============================================================================
// Module      : valid_ready_multichannel_fifo
// Description : CHANNELS independent queues of DEPTH words each. Writes are
//               tagged with a channel index; reads drain non-empty queues
//               through one round-robin arbitrated port with a grant lock
//               while the consumer stalls.
//               Optional feature macro:
//               VALID_READY_MULTICHANNEL_FIFO_ALMOST_FULL_EN (per-channel
//               almost-full flags at ALMOST_FULL_THRESHOLD occupancy).
// Revision    : 1.0 - initial release
// ============================================================================
module valid_ready_multichannel_fifo #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 4,
    parameter int CHANNELS      = 4,
    parameter int CHANNEL_WIDTH = $clog2(CHANNELS)
`ifdef VALID_READY_MULTICHANNEL_FIFO_ALMOST_FULL_EN
    ,
    parameter int ALMOST_FULL_THRESHOLD = DEPTH - 1
`endif
) (
    input  wire logic                      clock,
    input  wire logic                      reset,
    valid_ready_multichannel_fifo_if.slave fifo_bus
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_last_ptr  = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);
    localparam logic [CHANNEL_WIDTH-1:0] c_last_ch = CHANNEL_WIDTH'(CHANNELS - 1);
`ifdef VALID_READY_MULTICHANNEL_FIFO_ALMOST_FULL_EN
    localparam logic [c_cnt_w-1:0] c_af_cnt = c_cnt_w'(ALMOST_FULL_THRESHOLD);
`endif

    logic [CHANNELS-1:0]            w_full;
    logic [CHANNELS-1:0]            w_empty;
    logic [CHANNELS-1:0]            w_push;
    logic [CHANNELS-1:0]            w_pop;
    logic [CHANNELS-1:0][WIDTH-1:0] w_head;
`ifdef VALID_READY_MULTICHANNEL_FIFO_ALMOST_FULL_EN
    logic [CHANNELS-1:0]            w_almost_full;
`endif

    logic [CHANNEL_WIDTH-1:0] r_prio;
    logic                     r_locked;
    logic [CHANNEL_WIDTH-1:0] r_lock_ch;

    logic [CHANNEL_WIDTH-1:0] w_search_ch;
    logic                     w_search_found;
    logic [CHANNEL_WIDTH-1:0] w_grant;
    logic                     w_read_valid;
    logic                     w_channel_ok;
    logic                     w_write_ready;
    logic                     w_write_fire;
    logic                     w_read_fire;

    // Widened compare so the range check stays meaningful for any CHANNELS
    assign w_channel_ok  = ({1'b0, fifo_bus.write_channel} < (CHANNEL_WIDTH + 1)'(CHANNELS));
    // Full check looks only at registered state: no write-through on a full queue
    assign w_write_ready = w_channel_ok && !w_full[fifo_bus.write_channel];
    assign w_write_fire  = fifo_bus.write_valid && w_write_ready;
    assign w_read_fire   = w_read_valid && fifo_bus.read_ready;

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
            logic [WIDTH-1:0]   r_mem [DEPTH];
            logic [c_ptr_w-1:0] r_wr_ptr;
            logic [c_ptr_w-1:0] r_rd_ptr;
            logic [c_cnt_w-1:0] r_count;

            assign w_push[c]  = w_write_fire && (fifo_bus.write_channel == CHANNEL_WIDTH'(c));
            assign w_pop[c]   = w_read_fire && (w_grant == CHANNEL_WIDTH'(c));
            assign w_full[c]  = (r_count == c_depth_cnt);
            assign w_empty[c] = (r_count == '0);
            assign w_head[c]  = r_mem[r_rd_ptr];
`ifdef VALID_READY_MULTICHANNEL_FIFO_ALMOST_FULL_EN
            assign w_almost_full[c] = (r_count >= c_af_cnt);
`endif

            // Storage: data is not cleared by reset, only the pointers are
            always_ff @(posedge clock) begin
                if (w_push[c]) begin
                    r_mem[r_wr_ptr] <= fifo_bus.write_data;
                end
            end

            // Pointer and occupancy bookkeeping with explicit wrap at DEPTH-1
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push[c]) begin
                        r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_w'(1);
                    end
                    if (w_pop[c]) begin
                        r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_w'(1);
                    end
                    if (w_push[c] && !w_pop[c]) begin
                        r_count <= r_count + c_cnt_w'(1);
                    end else if (w_pop[c] && !w_push[c]) begin
                        r_count <= r_count - c_cnt_w'(1);
                    end
                end
            end
        end
    endgenerate

    // Round-robin search: first non-empty channel at or after r_prio, modulo
    // CHANNELS. Iterating downwards lets the nearest candidate win.
    always_comb begin
        w_search_found = 1'b0;
        w_search_ch    = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            int idx;
            idx = int'(r_prio) + i;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!w_empty[CHANNEL_WIDTH'(idx)]) begin
                w_search_found = 1'b1;
                w_search_ch    = CHANNEL_WIDTH'(idx);
            end
        end
    end

    // A stalled grant is held; the held queue cannot drain without a pop,
    // so it is guaranteed to still be non-empty.
    assign w_grant      = r_locked ? r_lock_ch : w_search_ch;
    assign w_read_valid = r_locked || w_search_found;

    // Arbiter state: priority pointer and grant lock during consumer stalls
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prio    <= '0;
            r_locked  <= 1'b0;
            r_lock_ch <= '0;
        end else begin
            r_locked  <= w_read_valid && !fifo_bus.read_ready;
            r_lock_ch <= w_grant;
            if (w_read_fire) begin
                r_prio <= (w_grant == c_last_ch) ? '0 : w_grant + CHANNEL_WIDTH'(1);
            end
        end
    end

    assign fifo_bus.write_ready  = w_write_ready;
    assign fifo_bus.write_full   = w_full;
    assign fifo_bus.read_empty   = w_empty;
    assign fifo_bus.read_valid   = w_read_valid;
    assign fifo_bus.read_channel = w_read_valid ? w_grant : '0;
    assign fifo_bus.read_data    = w_read_valid ? w_head[w_grant] : '0;
`ifdef VALID_READY_MULTICHANNEL_FIFO_ALMOST_FULL_EN
    assign fifo_bus.write_almost_full = w_almost_full;
`endif

endmodule
`default_nettype wire
